// File: rtl/decode_stage_pkg.sv
// Shared RV32I front-end definitions: opcodes, exception causes and the
// decoded-instruction record held by the decode pipeline register.
package decode_stage_pkg;

   localparam int EXCEPTION_CODE_WIDTH = 4;

   localparam logic [EXCEPTION_CODE_WIDTH-1:0] EXCEPTION_INSTR_MISALIGNED  = 4'd0;
   localparam logic [EXCEPTION_CODE_WIDTH-1:0] EXCEPTION_INSTR_ACCESS      = 4'd1;
   localparam logic [EXCEPTION_CODE_WIDTH-1:0] EXCEPTION_ILLEGAL_INSTR     = 4'd2;
   localparam logic [EXCEPTION_CODE_WIDTH-1:0] EXCEPTION_BREAKPOINT        = 4'd3;
   localparam logic [EXCEPTION_CODE_WIDTH-1:0] EXCEPTION_LOAD_MISALIGNED   = 4'd4;
   localparam logic [EXCEPTION_CODE_WIDTH-1:0] EXCEPTION_LOAD_ACCESS       = 4'd5;
   localparam logic [EXCEPTION_CODE_WIDTH-1:0] EXCEPTION_STORE_MISALIGNED  = 4'd6;
   localparam logic [EXCEPTION_CODE_WIDTH-1:0] EXCEPTION_STORE_ACCESS      = 4'd7;
   localparam logic [EXCEPTION_CODE_WIDTH-1:0] EXCEPTION_ECALL_U           = 4'd8;
   localparam logic [EXCEPTION_CODE_WIDTH-1:0] EXCEPTION_ECALL_M           = 4'd11;

   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
   localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

   // bit positions inside the packed class-flag vector
   localparam int CLS_ALU    = 11;
   localparam int CLS_LUI    = 10;
   localparam int CLS_AUIPC  = 9;
   localparam int CLS_BRANCH = 8;
   localparam int CLS_JAL    = 7;
   localparam int CLS_JALR   = 6;
   localparam int CLS_LOAD   = 5;
   localparam int CLS_STORE  = 4;
   localparam int CLS_CSR    = 3;
   localparam int CLS_MRET   = 2;
   localparam int CLS_WFI    = 1;
   localparam int CLS_FENCE  = 0;
   localparam int CLS_W      = 12;

   typedef struct packed {
      logic [31:0]                     pc;
      logic [31:0]                     next_pc;
      logic [4:0]                      rs1;
      logic [4:0]                      rs2;
      logic [4:0]                      rd;
      logic [31:0]                     imm;
      logic [2:0]                      funct3;
      logic                            funct7b5;
      logic                            uses_rs1;
      logic                            uses_rs2;
      logic                            writes_rd;
      logic [CLS_W-1:0]                cls;
      logic                            exc;
      logic [EXCEPTION_CODE_WIDTH-1:0] ecause;
   } dec_t;

endpackage

// File: rtl/decode_stage_decoder.sv
// Purely combinational RV32I word decoder: fields, immediate, usage/class
// flags and decode exceptions.
module rv32i_decoder
   import decode_stage_pkg::*;
(
   input  logic [31:0]                     instruction,
   output logic [4:0]                      rs1,
   output logic [4:0]                      rs2,
   output logic [4:0]                      rd,
   output logic [31:0]                     imm,
   output logic [2:0]                      funct3,
   output logic                            funct7b5,
   output logic                            uses_rs1,
   output logic                            uses_rs2,
   output logic                            writes_rd,
   output logic [CLS_W-1:0]                cls,
   output logic                            exception_valid,
   output logic [EXCEPTION_CODE_WIDTH-1:0] ecause
);

   logic [6:0]       opc;
   logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [CLS_W-1:0] cls_raw;
   logic             wr_raw, illegal, ecall, ebreak;

   assign opc      = instruction[6:0];
   assign rs1      = instruction[19:15];
   assign rs2      = instruction[24:20];
   assign rd       = instruction[11:7];
   assign funct3   = instruction[14:12];
   assign funct7b5 = instruction[30];

   assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
   assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
   assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
   assign imm_u = {instruction[31:12], 12'b0};
   assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};

   always_comb begin
      cls_raw  = '0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      wr_raw   = 1'b0;
      imm      = imm_i;
      illegal  = 1'b0;
      ecall    = 1'b0;
      ebreak   = 1'b0;
      case (opc)
         OPC_OP:       begin cls_raw[CLS_ALU] = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; wr_raw = 1'b1; end
         OPC_OP_IMM:   begin cls_raw[CLS_ALU] = 1'b1; uses_rs1 = 1'b1; wr_raw = 1'b1; end
         OPC_LOAD:     begin cls_raw[CLS_LOAD] = 1'b1; uses_rs1 = 1'b1; wr_raw = 1'b1; end
         OPC_STORE:    begin cls_raw[CLS_STORE] = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_s; end
         OPC_BRANCH:   begin cls_raw[CLS_BRANCH] = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_b; end
         OPC_JAL:      begin cls_raw[CLS_JAL] = 1'b1; wr_raw = 1'b1; imm = imm_j; end
         OPC_JALR:     begin cls_raw[CLS_JALR] = 1'b1; uses_rs1 = 1'b1; wr_raw = 1'b1; end
         OPC_LUI:      begin cls_raw[CLS_LUI] = 1'b1; wr_raw = 1'b1; imm = imm_u; end
         OPC_AUIPC:    begin cls_raw[CLS_AUIPC] = 1'b1; wr_raw = 1'b1; imm = imm_u; end
         OPC_MISC_MEM: cls_raw[CLS_FENCE] = 1'b1;
         OPC_SYSTEM: begin
            if (funct3 == 3'b000) begin
               case (instruction)
                  INSTR_ECALL:  ecall  = 1'b1;
                  INSTR_EBREAK: ebreak = 1'b1;
                  INSTR_MRET:   cls_raw[CLS_MRET] = 1'b1;
                  INSTR_WFI:    cls_raw[CLS_WFI]  = 1'b1;
                  default:      illegal = 1'b1;
               endcase
            end else begin
               // funct3[2] selects the immediate (zimm) CSR forms, which carry no rs1
               cls_raw[CLS_CSR] = 1'b1;
               uses_rs1         = ~funct3[2];
               wr_raw           = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase
      if (instruction[1:0] != 2'b11) illegal = 1'b1;
   end

   assign exception_valid = illegal | ecall | ebreak;
   assign ecause = illegal ? EXCEPTION_ILLEGAL_INSTR :
                   ecall   ? EXCEPTION_ECALL_M :
                   ebreak  ? EXCEPTION_BREAKPOINT : '0;
   assign cls       = exception_valid ? '0 : cls_raw;
   assign writes_rd = wr_raw && (rd != 5'd0) && !exception_valid;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: pops the FWFT instruction buffer, decodes, and holds
// the result in one valid/ready pipeline register killed by redirects.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int EXCEPTION_CODE_WIDTH = decode_stage_pkg::EXCEPTION_CODE_WIDTH
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            ins_empty,
   input  logic [31:0]                     pc_in,
   input  logic [31:0]                     next_pc_in,
   input  logic [31:0]                     instruction_in,
   output logic                            rd_en,
   input  logic                            flush,
   input  logic                            ready_i,
   output logic                            valid_o,
   output logic [31:0]                     pc_o,
   output logic [31:0]                     next_pc_o,
   output logic [4:0]                      rs1_o,
   output logic [4:0]                      rs2_o,
   output logic [4:0]                      rd_o,
   output logic [31:0]                     imm_o,
   output logic [2:0]                      funct3_o,
   output logic                            funct7b5_o,
   output logic                            uses_rs1_o,
   output logic                            uses_rs2_o,
   output logic                            writes_rd_o,
   output logic                            is_alu_o,
   output logic                            is_lui_o,
   output logic                            is_auipc_o,
   output logic                            is_branch_o,
   output logic                            is_jal_o,
   output logic                            is_jalr_o,
   output logic                            is_load_o,
   output logic                            is_store_o,
   output logic                            is_csr_o,
   output logic                            is_mret_o,
   output logic                            is_wfi_o,
   output logic                            is_fence_o,
   output logic                            exception_valid_o,
   output logic [EXCEPTION_CODE_WIDTH-1:0] ecause_o
);

   dec_t dec, q;
   logic valid_q;

   assign dec.pc      = pc_in;
   assign dec.next_pc = next_pc_in;

   rv32i_decoder u_dec (
      .instruction     (instruction_in),
      .rs1             (dec.rs1),
      .rs2             (dec.rs2),
      .rd              (dec.rd),
      .imm             (dec.imm),
      .funct3          (dec.funct3),
      .funct7b5        (dec.funct7b5),
      .uses_rs1        (dec.uses_rs1),
      .uses_rs2        (dec.uses_rs2),
      .writes_rd       (dec.writes_rd),
      .cls             (dec.cls),
      .exception_valid (dec.exc),
      .ecause          (dec.ecause)
   );

   // Pop decision never looks at the instruction word, keeping it off the
   // buffer's read-enable timing path.
   assign rd_en = !ins_empty && !flush && (!valid_q || ready_i);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         q       <= '0;
      end else if (rd_en) begin
         valid_q <= 1'b1;
         q       <= dec;
      end else if (flush || ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o           = valid_q;
   assign pc_o              = q.pc;
   assign next_pc_o         = q.next_pc;
   assign rs1_o             = q.rs1;
   assign rs2_o             = q.rs2;
   assign rd_o              = q.rd;
   assign imm_o             = q.imm;
   assign funct3_o          = q.funct3;
   assign funct7b5_o        = q.funct7b5;
   assign uses_rs1_o        = q.uses_rs1;
   assign uses_rs2_o        = q.uses_rs2;
   assign writes_rd_o       = q.writes_rd;
   assign is_alu_o          = q.cls[CLS_ALU];
   assign is_lui_o          = q.cls[CLS_LUI];
   assign is_auipc_o        = q.cls[CLS_AUIPC];
   assign is_branch_o       = q.cls[CLS_BRANCH];
   assign is_jal_o          = q.cls[CLS_JAL];
   assign is_jalr_o         = q.cls[CLS_JALR];
   assign is_load_o         = q.cls[CLS_LOAD];
   assign is_store_o        = q.cls[CLS_STORE];
   assign is_csr_o          = q.cls[CLS_CSR];
   assign is_mret_o         = q.cls[CLS_MRET];
   assign is_wfi_o          = q.cls[CLS_WFI];
   assign is_fence_o        = q.cls[CLS_FENCE];
   assign exception_valid_o = q.exc;
   assign ecause_o          = EXCEPTION_CODE_WIDTH'(q.ecause);

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a modelled FWFT buffer feeds a table of
// hand-decoded RV32I words; expectations queue on each pop, retire on accept.
module tb_decode_stage;

   localparam logic [11:0] F_ALU = 12'h800, F_LUI = 12'h400, F_BR = 12'h100,
                           F_JAL = 12'h080, F_LD = 12'h020, F_ST = 12'h010,
                           F_CSR = 12'h008, F_MRET = 12'h004;

   typedef struct {
      logic [31:0] ins, pc, npc, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic        f7;
      logic [11:0] flags;
      logic        u1, u2, wr, exc;
      logic [3:0]  ec;
   } ent_t;

   logic        clk = 1'b0, reset, ins_empty, rd_en, flush, ready_i, valid_o;
   logic [31:0] pc_in, next_pc_in, instruction_in, pc_o, next_pc_o, imm_o;
   logic [4:0]  rs1_o, rs2_o, rd_o;
   logic [2:0]  funct3_o;
   logic        funct7b5_o, uses_rs1_o, uses_rs2_o, writes_rd_o;
   logic        is_alu_o, is_lui_o, is_auipc_o, is_branch_o, is_jal_o, is_jalr_o;
   logic        is_load_o, is_store_o, is_csr_o, is_mret_o, is_wfi_o, is_fence_o;
   logic        exception_valid_o;
   logic [3:0]  ecause_o;

   decode_stage dut (
      .clk(clk), .reset(reset), .ins_empty(ins_empty), .pc_in(pc_in),
      .next_pc_in(next_pc_in), .instruction_in(instruction_in), .rd_en(rd_en),
      .flush(flush), .ready_i(ready_i), .valid_o(valid_o), .pc_o(pc_o),
      .next_pc_o(next_pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
      .imm_o(imm_o), .funct3_o(funct3_o), .funct7b5_o(funct7b5_o),
      .uses_rs1_o(uses_rs1_o), .uses_rs2_o(uses_rs2_o), .writes_rd_o(writes_rd_o),
      .is_alu_o(is_alu_o), .is_lui_o(is_lui_o), .is_auipc_o(is_auipc_o),
      .is_branch_o(is_branch_o), .is_jal_o(is_jal_o), .is_jalr_o(is_jalr_o),
      .is_load_o(is_load_o), .is_store_o(is_store_o), .is_csr_o(is_csr_o),
      .is_mret_o(is_mret_o), .is_wfi_o(is_wfi_o), .is_fence_o(is_fence_o),
      .exception_valid_o(exception_valid_o), .ecause_o(ecause_o)
   );

   always #5 clk = ~clk;

   int   checks = 0, errors = 0;
   ent_t tbl[12];
   int   bq[$];
   ent_t sb[$];
   bit   started = 1'b0, do_pop = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic ent_t mk(input int i, input logic [31:0] ins, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                               input logic [2:0] f3, input logic f7, input logic [11:0] fl,
                               input logic u1, input logic u2, input logic wr,
                               input logic exc, input logic [3:0] ec);
      ent_t e;
      e.ins = ins; e.pc = 32'h8000_0000 + 32'(i * 4); e.npc = e.pc + 32'd4;
      e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm; e.f3 = f3; e.f7 = f7;
      e.flags = fl; e.u1 = u1; e.u2 = u2; e.wr = wr; e.exc = exc; e.ec = ec;
      return e;
   endfunction

   function automatic void update_head();
      ins_empty = (bq.size() == 0);
      if (bq.size() != 0) begin
         pc_in = tbl[bq[0]].pc; next_pc_in = tbl[bq[0]].npc; instruction_in = tbl[bq[0]].ins;
      end else begin
         pc_in = 32'h0; next_pc_in = 32'h0; instruction_in = 32'hDEAD_BEEF;
      end
   endfunction

   // Monitor: sampled mid-cycle; also predicts what the coming edge does.
   always @(negedge clk) begin
      if (started) begin
         automatic bit mvalid = (sb.size() != 0);
         automatic bit exp_rd = !ins_empty && !flush && (!mvalid || ready_i);
         chk("valid_o", {31'b0, valid_o}, {31'b0, mvalid});
         chk("rd_en", {31'b0, rd_en}, {31'b0, exp_rd});
         if (mvalid) begin
            automatic ent_t e = sb[0];
            chk("pc_o", pc_o, e.pc);
            chk("next_pc_o", next_pc_o, e.npc);
            chk("rs1_o", {27'b0, rs1_o}, {27'b0, e.rs1});
            chk("rs2_o", {27'b0, rs2_o}, {27'b0, e.rs2});
            chk("rd_o", {27'b0, rd_o}, {27'b0, e.rd});
            chk("imm_o", imm_o, e.imm);
            chk("funct3_o", {29'b0, funct3_o}, {29'b0, e.f3});
            chk("funct7b5_o", {31'b0, funct7b5_o}, {31'b0, e.f7});
            chk("class", {20'b0, is_alu_o, is_lui_o, is_auipc_o, is_branch_o, is_jal_o,
                          is_jalr_o, is_load_o, is_store_o, is_csr_o, is_mret_o,
                          is_wfi_o, is_fence_o}, {20'b0, e.flags});
            chk("usage", {29'b0, uses_rs1_o, uses_rs2_o, writes_rd_o},
                {29'b0, e.u1, e.u2, e.wr});
            chk("exception_valid_o", {31'b0, exception_valid_o}, {31'b0, e.exc});
            chk("ecause_o", {28'b0, ecause_o}, {28'b0, e.ec});
         end
         do_pop = 1'b0;
         if (reset || flush) sb.delete();
         else begin
            if (mvalid && ready_i) void'(sb.pop_front());
            if (exp_rd) begin
               sb.push_back(tbl[bq[0]]);
               do_pop = 1'b1;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (do_pop) begin
         void'(bq.pop_front());
         do_pop = 1'b0;
         update_head();
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic push(input int i);
      bq.push_back(i);
      update_head();
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || bq.size() != 0) && n < 40) begin step(); n++; end
      chk("drain_timeout", {31'b0, (sb.size() != 0 || bq.size() != 0)}, 32'h0);
   endtask

   initial begin
      tbl[0]  = mk(0,  32'h0050_0093, 0, 5, 1, 32'h5,         0, 0, F_ALU,  1, 0, 1, 0, 0);
      tbl[1]  = mk(1,  32'hFE00_0EE3, 0, 0, 29, 32'hFFFF_FFFC, 0, 1, F_BR,  1, 1, 0, 0, 0);
      tbl[2]  = mk(2,  32'h0020_81B3, 1, 2, 3, 32'h2,         0, 0, F_ALU,  1, 1, 1, 0, 0);
      tbl[3]  = mk(3,  32'h0020_A423, 1, 2, 8, 32'h8,         2, 0, F_ST,   1, 1, 0, 0, 0);
      tbl[4]  = mk(4,  32'h00C0_A283, 1, 12, 5, 32'hC,        2, 0, F_LD,   1, 0, 1, 0, 0);
      tbl[5]  = mk(5,  32'h0100_00EF, 0, 16, 1, 32'h10,       0, 0, F_JAL,  0, 0, 1, 0, 0);
      tbl[6]  = mk(6,  32'h1234_5037, 8, 3, 0, 32'h1234_5000, 5, 0, F_LUI,  0, 0, 0, 0, 0);
      tbl[7]  = mk(7,  32'h3020_0073, 0, 2, 0, 32'h302,       0, 0, F_MRET, 0, 0, 0, 0, 0);
      tbl[8]  = mk(8,  32'h0000_0000, 0, 0, 0, 32'h0,         0, 0, 12'h0,  0, 0, 0, 1, 4'd2);
      tbl[9]  = mk(9,  32'h0000_0073, 0, 0, 0, 32'h0,         0, 0, 12'h0,  0, 0, 0, 1, 4'd11);
      tbl[10] = mk(10, 32'h0010_0073, 0, 1, 0, 32'h1,         0, 0, 12'h0,  0, 0, 0, 1, 4'd3);
      tbl[11] = mk(11, 32'h3000_92F3, 1, 0, 5, 32'h300,       1, 0, F_CSR,  1, 0, 1, 0, 0);

      reset = 1'b1; flush = 1'b0; ready_i = 1'b0;
      update_head();
      step();
      started = 1'b1;
      step();
      chk("rst_valid", {31'b0, valid_o}, 32'h0);
      chk("rst_imm", imm_o, 32'h0);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_rd", {27'b0, rd_o}, 32'h0);
      chk("rst_ecause", {28'b0, ecause_o}, 32'h0);
      chk("rst_rd_en", {31'b0, rd_en}, 32'h0);
      reset = 1'b0;

      // single addi, then a 3-cycle stall on a branch
      ready_i = 1'b1; push(0); drain();
      ready_i = 1'b0; push(1);
      repeat (4) step();
      chk("stall_held", {31'b0, valid_o}, 32'h1);
      ready_i = 1'b1; drain();

      // back-to-back stream: four consecutive valid cycles, then empty
      push(2); push(3); push(4); push(5);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("stream_valid", {31'b0, valid_o}, 32'h1);
      end
      step();
      chk("stream_end", {31'b0, valid_o}, 32'h0);

      // flush while stalled with the buffer still holding a word
      ready_i = 1'b0; push(6); push(7);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0; bq.delete(); update_head();
      chk("flush_kill", {31'b0, valid_o}, 32'h0);

      // exceptions, then lui x0 / mret / csrrw
      ready_i = 1'b1;
      push(8); push(9); push(10); drain();
      push(6); push(7); push(11); drain();

      // reset in the middle of a stall with a non-empty buffer
      ready_i = 1'b0; push(0); push(2);
      repeat (2) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_valid", {31'b0, valid_o}, 32'h0);
      chk("midrst_imm", imm_o, 32'h0);
      ready_i = 1'b1; drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got %0d exp 0", checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Single-cycle RV32I decode stage directly downstream of the fetch unit's instruction buffer. It pops one instruction per cycle from the first-word-fall-through buffer and decodes it into register indices, a sign-extended immediate and class flags. The result is held in one pipeline register with a valid/ready handshake toward issue. A redirect (branch, trap, mret) kills the held entry.

## Interface
Parameters:
- EXCEPTION_CODE_WIDTH, from shared package, width of ecause_o.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ins_empty  in  1  instruction buffer empty
- pc_in  in  32  buffer head PC; valid when !ins_empty
- next_pc_in  in  32  buffer head next PC
- instruction_in  in  32  buffer head instruction word
- rd_en  out  1  pop buffer head at next clk edge
- flush  in  1  redirect: real-branch mismatch, trap or mret
- ready_i  in  1  issue accepts the current output
- valid_o  out  1  output register holds a decoded instruction
- pc_o, next_pc_o  out  32 each  registered PCs
- rs1_o, rs2_o, rd_o  out  5 each  instruction[19:15], [24:20], [11:7]
- imm_o  out  32  sign-extended immediate
- funct3_o  out  3  instruction[14:12]
- funct7b5_o  out  1  instruction[30]
- uses_rs1_o, uses_rs2_o, writes_rd_o  out  1 each  register-usage flags
- is_alu_o, is_lui_o, is_auipc_o, is_branch_o, is_jal_o, is_jalr_o, is_load_o, is_store_o, is_csr_o, is_mret_o, is_wfi_o, is_fence_o  out  1 each  class flags
- exception_valid_o  out  1  decode exception on the held instruction
- ecause_o  out  EXCEPTION_CODE_WIDTH  cause code; 0 when none

## Operation
- Pop condition: rd_en = !ins_empty && !flush && (!valid_o || ready_i).
- On a pop, the output register loads the decoded head. Otherwise:
  - valid_o clears on ready_i && valid_o or on flush.
  - All other output fields hold.
- Immediate formats, all sign-extended from instruction[31]:
  - I: [31:20]. Used by OP-IMM, LOAD, JALR.
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R-type and SYSTEM: imm_o = I-format, which carries the CSR address.
- Register-usage flags:
  - uses_rs1_o: OP, OP-IMM, LOAD, STORE, BRANCH, JALR, and CSR with funct3[2]=0.
  - uses_rs2_o: OP, STORE, BRANCH.
  - writes_rd_o: OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, CSR. Forced 0 when rd_o==0 or on an exception.
- Exceptions, in priority order:
  - instruction[1:0]!=2'b11, unknown opcode, or SYSTEM funct3=0 with an unlisted word: EXCEPTION_ILLEGAL_INSTR.
  - ECALL (0x00000073): EXCEPTION_ECALL_M.
  - EBREAK (0x00100073): EXCEPTION_BREAKPOINT.
  - On any exception, all class flags are 0.
- MRET is 0x30200073; WFI is 0x10500073.

## Timing
- Reset: valid_o=0 and every output field 0. rd_en follows its combinational equation, so it is 0 while ins_empty=1.
- Latency: 1 cycle from pop to valid_o. Sustained throughput is 1/cycle while ready_i=1 and the buffer is non-empty.
- Handshake: while valid_o && !ready_i, all outputs are stable and rd_en=0.
- flush has priority over a pop and over ready_i:
  - The cycle after flush, valid_o=0.
  - No pop occurs in the flush cycle. The buffer flushes itself the same cycle.
- Buffer empty with ready_i=1: valid_o drops the next cycle. No bubble-fill logic.
- Reset asserted mid-stall: valid_o=0 the next cycle, and no pop occurs in the reset cycle.
- rd_en is combinational from ins_empty, flush, valid_o and ready_i. It has no path from instruction_in.

## Structure
- The shared package holds:
  - Opcode constants: OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_MISC_MEM.
  - Exception codes: EXCEPTION_ILLEGAL_INSTR, EXCEPTION_ECALL_M, EXCEPTION_BREAKPOINT, alongside the existing EXCEPTION_* codes and EXCEPTION_CODE_WIDTH.
- One sub-module, rv32i_decoder: purely combinational, instruction word in, fields, flags and exception out.
- The handshake register stays in decode_stage.

## Test plan
- Reset, then buffer head 0x00500093 (addi x1,x0,5) at pc 0x80000000, ready_i=1 → rd_en=1 the same cycle. Next cycle:
  - valid_o=1, rd_o=1, imm_o=5, is_alu_o=1, writes_rd_o=1, uses_rs2_o=0.
- Head 0xFE000EE3 (beq x0,x0,-4) with ready_i=0 for 3 cycles:
  - valid_o=1 held, imm_o=0xFFFFFFFC, is_branch_o=1.
  - rd_en=0 while stalled; one pop after ready_i rises.
- Back-to-back stream of 4 instructions with ready_i=1 → 4 consecutive valid cycles, in order, no bubbles.
- flush asserted while valid_o=1, ready_i=0 and the buffer is non-empty → rd_en=0 that cycle; valid_o=0 the next cycle.
- Words 0x00000000, 0x00000073, 0x00100073 →
  - ecause_o = ILLEGAL_INSTR, ECALL_M, BREAKPOINT respectively.
  - exception_valid_o=1 and all class flags 0 for each.
- lui x0,0x12345 (0x12345037) → imm_o=0x12345000, is_lui_o=1, writes_rd_o=0.
